// File: rtl/eth_pkt_rd_ctrl_if.sv
// Handshake bundle between the packet FIFO read port, the UDP TX engine and eth_pkt_rd_ctrl.
// master = the read controller, slave = the FIFO/TX environment.
interface eth_pkt_rd_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH:0]   fifo_rd_water_level;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  tx_req;
    logic                  tx_done;
    logic                  tx_start_en;
    logic [15:0]           tx_byte_num;
    logic [DATA_WIDTH-1:0] tx_data;

    modport master (
        input  fifo_rd_water_level, fifo_empty, fifo_rd_data, tx_req, tx_done,
        output fifo_rd_en, tx_start_en, tx_byte_num, tx_data
    );

    modport slave (
        output fifo_rd_water_level, fifo_empty, fifo_rd_data, tx_req, tx_done,
        input  fifo_rd_en, tx_start_en, tx_byte_num, tx_data
    );
endinterface

// File: rtl/eth_pkt_rd_ctrl.sv
// Moves fixed-size packets from the upstream packet FIFO into the UDP TX engine.
// Optional packet counter output pkt_cnt is built when ETH_PKT_CNT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | wait for FIFO water level to cover one whole packet
// START     | one-cycle tx_start_en pulse, word counter cleared
// SEND      | serve tx_req: read FIFO (or underflow) until PKT_WORDS words
// WAIT_DONE | all words handed over, wait for tx_done
// GAP       | GAP_CYCLES idle cycles before the level is looked at again
module eth_pkt_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int PKT_WORDS  = 256,
    parameter int GAP_CYCLES = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    eth_pkt_rd_ctrl_if.master  bus,
    output logic               underflow_err,
    output logic               busy
`ifdef ETH_PKT_CNT_EN
    ,
    output logic [15:0]        pkt_cnt
`endif
);

    localparam int              CW       = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   PKT_W    = CW'(PKT_WORDS);
    localparam logic [CW-1:0]   PKT_LAST = CW'(PKT_WORDS - 1);
    localparam logic [7:0]      GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [15:0]     BYTE_NUM = 16'(PKT_WORDS * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                state;
    logic [CW-1:0]         word_cnt;
    logic [7:0]            gap_cnt;
    logic                  start_q;
    logic [15:0]           byte_num_q;
    logic                  rd_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  req_acc;
    logic                  req_uf;

    assign req_acc        = (state == S_SEND) && bus.tx_req && (word_cnt < PKT_W);
    assign req_uf         = req_acc && bus.fifo_empty;
    assign bus.fifo_rd_en = rst_n && req_acc && !bus.fifo_empty;

    // FIFO has no output register, so the word read last cycle is passed straight through;
    // data_q holds the last word (or 0 after an underflowed request) on other cycles.
    assign bus.tx_data     = rd_d ? bus.fifo_rd_data : data_q;
    assign bus.tx_start_en = start_q;
    assign bus.tx_byte_num = byte_num_q;
    assign busy            = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            word_cnt      <= '0;
            gap_cnt       <= '0;
            start_q       <= 1'b0;
            byte_num_q    <= BYTE_NUM;
            rd_d          <= 1'b0;
            data_q        <= '0;
            underflow_err <= 1'b0;
`ifdef ETH_PKT_CNT_EN
            pkt_cnt       <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            rd_d    <= bus.fifo_rd_en;

            if (req_uf)
                data_q <= '0;
            else if (rd_d)
                data_q <= bus.fifo_rd_data;

            if (req_uf)
                underflow_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.fifo_rd_water_level >= PKT_W) begin
                        state   <= S_START;
                        start_q <= 1'b1;
                    end
                end
                S_START: begin
                    word_cnt <= '0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (req_acc) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == PKT_LAST)
                            state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_LOAD;
`ifdef ETH_PKT_CNT_EN
                        pkt_cnt <= pkt_cnt + 16'd1;
`endif
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 8'd0)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt - 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_pkt_rd_ctrl.sv
// Randomized scoreboard bench for eth_pkt_rd_ctrl: FIFO/TX environment, word-level reference
// model and a decoupled tx_data monitor.
module tb_eth_pkt_rd_ctrl;

    localparam int          PKT   = 256;
    localparam int          GAP   = 12;
    localparam logic [15:0] BYTES = 16'd1024;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk_tb;
    logic tb_rst;
    logic underflow_err;
    logic busy;
`ifdef ETH_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    eth_pkt_rd_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

    eth_pkt_rd_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(10),
        .PKT_WORDS (PKT),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk          (clk_tb),
        .rst_n        (tb_rst),
        .bus          (bus),
        .underflow_err(underflow_err),
        .busy         (busy)
`ifdef ETH_PKT_CNT_EN
        ,
        .pkt_cnt      (pkt_cnt)
`endif
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_reads = 0;
    bit          uf_model = 1'b0;
    int          pkt_model = 0;
    bit          alive = 1'b1;
    logic [31:0] fifo_q[$];
    exp_t        exp_q[$];

    always @(posedge clk_tb) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every accepted tx_req owes one tx_data word on the following cycle.
    always @(negedge clk_tb) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (e.due != cyc || bus.tx_data !== e.data) begin
                n_fail++;
                $display("FAIL tx_data due %0d @cyc %0d: got %0h expected %0h",
                         e.due, cyc, bus.tx_data, e.data);
            end
        end
    end

    task automatic refresh();
        bus.fifo_empty          = (fifo_q.size() == 0);
        bus.fifo_rd_water_level = 11'(fifo_q.size());
    endtask

    task automatic fill_fifo(input int n);
        while (fifo_q.size() < n) fifo_q.push_back($urandom);
        refresh();
    endtask

    // One clock: sample the read strobe mid-cycle, then the FIFO model serves it after the edge.
    task automatic tick();
        logic rd_s;
        @(negedge clk_tb);
        rd_s = bus.fifo_rd_en;
        if (!tb_rst) check("rd_en_in_reset", 32'(rd_s), 32'd0);
        if (rd_s) n_reads++;
        @(posedge clk_tb);
        #1;
        if (rd_s && fifo_q.size() > 0) bus.fifo_rd_data = fifo_q.pop_front();
        else bus.fifo_rd_data = $urandom;
        refresh();
    endtask

    task automatic push_req_expect();
        logic [31:0] ev;
        if (fifo_q.size() > 0) ev = fifo_q[0];
        else begin
            ev = '0;
            uf_model = 1'b1;
        end
        exp_q.push_back(exp_t'{due: cyc + 1, data: ev});
    endtask

    // Entered on the tx_start_en cycle; returns on the next packet's tx_start_en cycle.
    task automatic run_packet(input int density, input int extra, input int flush_at, input bit done_last);
        int reads0;
        int exp_reads;
        int i;
        int k;
        bit req;
        bit found;
        reads0    = n_reads;
        exp_reads = 0;
        bus.tx_req = 1'($urandom_range(0, 1));
        tick();
        bus.tx_req = 1'b0;
        check("start_pulse_width", 32'(bus.tx_start_en), 32'd0);
        i = 0;
        while (i < PKT) begin
            if (flush_at >= 0 && i == flush_at) fifo_q.delete();
            else if (flush_at >= 0 && i > flush_at && $urandom_range(0, 99) < 30) fifo_q.push_back($urandom);
            refresh();
            req = ($urandom_range(1, 100) <= density);
            bus.tx_req = req;
            if (req) begin
                if (fifo_q.size() > 0) exp_reads++;
                push_req_expect();
                i++;
                if (i == PKT && done_last) bus.tx_done = 1'b1;
            end
            tick();
            bus.tx_done = 1'b0;
        end
        for (int j = 0; j < extra; j++) begin
            bus.tx_req = 1'b1;
            tick();
        end
        bus.tx_req = 1'b0;
        fill_fifo(512);
        if (done_last) begin
            for (int j = 0; j < 20; j++) begin
                tick();
                if (bus.tx_start_en) break;
            end
            check("done_with_last_ignored", 32'(bus.tx_start_en), 32'd0);
        end
        check("pkt_reads", 32'(n_reads - reads0), 32'(exp_reads));
        check("underflow_err", 32'(underflow_err), 32'(uf_model));
        check("busy_wait_done", 32'(busy), 32'd1);
        repeat ($urandom_range(0, 3)) tick();
        bus.tx_done = 1'b1;
        pkt_model++;
        found = 1'b0;
        for (k = 1; k <= GAP + 20; k++) begin
            tick();
            bus.tx_done = 1'b0;
            if (k == GAP) check("busy_gap_end", 32'(busy), 32'd1);
            if (k == GAP + 1) check("busy_idle", 32'(busy), 32'd0);
            if (bus.tx_start_en) begin
                found = 1'b1;
                break;
            end
        end
        check("gap_to_start", found ? 32'(k) : 32'hFFFF_FFFF, 32'(GAP + 2));
        if (!found) alive = 1'b0;
`ifdef ETH_PKT_CNT_EN
        check("pkt_cnt", 32'(pkt_cnt), 32'(pkt_model[15:0]));
`endif
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads0;
        bit started;
        bit found;
        tb_rst           = 1'b0;
        bus.tx_req       = 1'b1;
        bus.tx_done      = 1'b0;
        bus.fifo_rd_data = '0;
        refresh();
        repeat (3) tick();
        check("rst_start_en", 32'(bus.tx_start_en), 32'd0);
        check("rst_tx_data", bus.tx_data, 32'd0);
        check("rst_underflow", 32'(underflow_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_byte_num", 32'(bus.tx_byte_num), 32'(BYTES));
        tb_rst     = 1'b1;
        bus.tx_req = 1'b0;

        for (int v = 1; v <= 255; v++) fifo_q.push_back(32'(v));
        refresh();
        repeat (5) begin
            tick();
            check("no_start_at_255", 32'(bus.tx_start_en), 32'd0);
        end
        check("idle_busy", 32'(busy), 32'd0);
        fifo_q.push_back(32'd256);
        refresh();
        tick();
        check("start_at_256", 32'(bus.tx_start_en), 32'd1);
        check("byte_num", 32'(bus.tx_byte_num), 32'(BYTES));

        run_packet(100, 0, -1, 1'b0);
        if (alive) run_packet(100, 3, 100, 1'b0);
        for (int p = 0; p < 6; p++)
            if (alive)
                run_packet($urandom_range(30, 100), $urandom_range(0, 4),
                           ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : -1,
                           1'($urandom_range(0, 1)));
        if (alive) run_packet(100, 0, -1, 1'b1);

        if (alive) begin
            bus.tx_req = 1'b0;
            tick();
            for (int w = 0; w < 50; w++) begin
                bus.tx_req = 1'b1;
                push_req_expect();
                tick();
            end
            tb_rst     = 1'b0;
            bus.tx_req = 1'b1;
            tick();
            tb_rst     = 1'b1;
            bus.tx_req = 1'b0;
            uf_model   = 1'b0;
            pkt_model  = 0;
            check("mid_rst_start_en", 32'(bus.tx_start_en), 32'd0);
            check("mid_rst_tx_data", bus.tx_data, 32'd0);
            check("mid_rst_underflow", 32'(underflow_err), 32'd0);
            check("mid_rst_busy", 32'(busy), 32'd0);
            check("mid_rst_byte_num", 32'(bus.tx_byte_num), 32'(BYTES));
`ifdef ETH_PKT_CNT_EN
            check("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
`endif
            while (fifo_q.size() > 100) void'(fifo_q.pop_back());
            refresh();
            reads0  = n_reads;
            started = 1'b0;
            repeat (20) begin
                bus.tx_req = 1'b1;
                tick();
                if (bus.tx_start_en) started = 1'b1;
            end
            bus.tx_req = 1'b0;
            check("post_rst_reads", 32'(n_reads - reads0), 32'd0);
            check("post_rst_no_start", 32'(started), 32'd0);
            fill_fifo(512);
            found = 1'b0;
            tick();
            if (bus.tx_start_en) found = 1'b1;
            check("post_rst_restart", 32'(found), 32'd1);
            if (found) run_packet(80, 1, -1, 1'b0);
        end

        bus.tx_req = 1'b0;
        repeat (5) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
